// File: rtl/tcp_vlg_tx_arb.sv
// Round-robin transmit arbiter between retransmission-queue entries and the stream engine.
// It grants one entry at a time, tracks send/sent and aborts a stalled transfer via a watchdog.
package tcp_vlg_pkg;
    typedef struct packed {
        logic [31:0] seq;
        logic [15:0] len;
    } tcp_pld_info_t;
endpackage

module tcp_vlg_tx_arb
    import tcp_vlg_pkg::*;
#(
    parameter int N   = 4,
    parameter int TMO = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N-1:0]           ent_val,
    input  tcp_pld_info_t          ent_info [N],
    output logic [N-1:0]           ent_ack,
    output logic [N-1:0]           ent_err,
    output logic                   pend,
    input  logic                   send,
    input  logic                   sent,
    output tcp_pld_info_t          pld_info,
    output logic [$clog2(N)-1:0]   gnt_idx,
    output logic                   busy
);
    localparam int IW = $clog2(N);
    localparam int WW = $clog2(TMO + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TMO - 1);
    localparam logic [N-1:0]  ONE     = N'(1);
    localparam logic [IW-1:0] LAST    = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, PEND, XMIT, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [WW-1:0]   wdt;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   cand;
    logic            found;
    logic [IW-1:0]   ptr_after;

    // First valid entry at or after ptr, wrapping modulo N.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && ent_val[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign ptr_after = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pend     <= 1'b0;
            busy     <= 1'b0;
            ent_ack  <= '0;
            ent_err  <= '0;
            gnt_idx  <= '0;
            ptr      <= '0;
            pld_info <= '0;
            wdt      <= '0;
        end else begin
            ent_ack <= '0;
            ent_err <= '0;
            case (state)
                IDLE: begin
                    if (en && found) begin
                        gnt_idx  <= sel;
                        pld_info <= ent_info[sel];
                        pend     <= 1'b1;
                        busy     <= 1'b1;
                        wdt      <= '0;
                        state    <= PEND;
                    end
                end
                PEND: begin
                    // An expiring watchdog takes precedence over a late accept.
                    if (wdt == WD_LAST) begin
                        ent_err <= ONE << gnt_idx;
                        pend    <= 1'b0;
                        ptr     <= ptr_after;
                        state   <= DONE;
                    end else begin
                        wdt <= wdt + 1'b1;
                        if (send) begin
                            pend  <= 1'b0;
                            state <= XMIT;
                        end
                    end
                end
                XMIT: begin
                    if (sent) begin
                        ent_ack <= ONE << gnt_idx;
                        ptr     <= ptr_after;
                        state   <= DONE;
                    end else if (wdt == WD_LAST) begin
                        ent_err <= ONE << gnt_idx;
                        ptr     <= ptr_after;
                        state   <= DONE;
                    end else begin
                        wdt <= wdt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tcp_vlg_tx_arb.sv
// Directed bench for tcp_vlg_tx_arb with a transaction-level reference model checked every cycle.
module tb_tcp_vlg_tx_arb;
    import tcp_vlg_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          send = 1'b0;
    logic          sent = 1'b0;
    logic [N-1:0]  ent_val = '0;
    tcp_pld_info_t ent_info [N];
    logic [N-1:0]  ent_ack;
    logic [N-1:0]  ent_err;
    logic          pend;
    tcp_pld_info_t pld_info;
    logic [1:0]    gnt_idx;
    logic          busy;

    int tests = 0;
    int fails = 0;

    tcp_vlg_tx_arb #(.N(N), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .en(en), .ent_val(ent_val), .ent_info(ent_info),
        .ent_ack(ent_ack), .ent_err(ent_err), .pend(pend), .send(send), .sent(sent),
        .pld_info(pld_info), .gnt_idx(gnt_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a granted packet ages one step per cycle; it is finished by sent
    // once accepted, or aborted when its age reaches TMO; a finished packet spends one
    // more cycle busy before the arbiter looks at requests again.
    bit            m_busy, m_pend, m_acc, m_done;
    logic [N-1:0]  m_ack, m_err;
    int            m_idx, m_ptr, m_age;
    tcp_pld_info_t m_info;

    task automatic model_finish(input bit ok);
        if (ok) m_ack = N'(1) << m_idx;
        else    m_err = N'(1) << m_idx;
        m_pend = 0;
        m_done = 1;
        m_ptr  = (m_idx + 1) % N;
    endtask

    task automatic model_step();
        bit got;
        m_ack = '0;
        m_err = '0;
        if (!m_busy) begin
            got = 0;
            if (en) begin
                for (int k = 0; k < N; k++) begin
                    if (!got && ent_val[(m_ptr + k) % N]) begin
                        got    = 1;
                        m_idx  = (m_ptr + k) % N;
                        m_info = ent_info[m_idx];
                    end
                end
            end
            if (got) begin
                m_busy = 1; m_pend = 1; m_acc = 0; m_done = 0; m_age = 0;
            end
        end else if (m_done) begin
            m_busy = 0;
            m_done = 0;
        end else begin
            m_age++;
            if (m_acc && sent)            model_finish(1);
            else if (m_age == TMO)        model_finish(0);
            else if (!m_acc && send) begin
                m_acc  = 1;
                m_pend = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_busy = 0; m_pend = 0; m_acc = 0; m_done = 0;
                m_ack = '0; m_err = '0; m_idx = 0; m_ptr = 0; m_age = 0; m_info = '0;
            end else begin
                model_step();
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_pend", pend, m_pend);
        check("cyc_busy", busy, m_busy);
        check("cyc_ack", ent_ack, m_ack);
        check("cyc_err", ent_err, m_err);
        check("cyc_gnt_idx", gnt_idx, m_idx[1:0]);
        check("cyc_pld_info", pld_info, m_info);
        check("cyc_ack_err_excl", (|ent_ack) && (|ent_err), 0);
        check("cyc_onehot", $onehot0(ent_ack) && $onehot0(ent_err), 1);
    end

    task automatic serve(input int exp_idx, input int sd, input int td);
        int c = 0;
        while (!pend && c < 50) begin
            tick();
            c++;
        end
        check("grant_pend", pend, 1);
        check("grant_idx", gnt_idx, exp_idx);
        repeat (sd) tick();
        send = 1'b1;
        tick();
        send = 1'b0;
        repeat (td - 1) tick();
        sent = 1'b1;
        tick();
        sent = 1'b0;
        check("ack_pulse", ent_ack, 64'(1) << exp_idx);
        check("ack_no_err", ent_err, 0);
        tick();
        check("ack_one_cycle", ent_ack, 0);
        check("busy_low", busy, 0);
        $display("[TB] xfer idx=%0d send_dly=%0d sent_dly=%0d", exp_idx, sd, td);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        for (int i = 0; i < N; i++) begin
            ent_info[i].seq = 32'h1000_0000 + 32'(i);
            ent_info[i].len = 16'(100 + i);
        end

        // Reset state
        tick();
        check("rst_pend", pend, 0);
        check("rst_busy", busy, 0);
        check("rst_gnt_idx", gnt_idx, 0);
        check("rst_pld_info", pld_info, 0);
        tick();
        rst = 1'b1;
        $display("[TB] reset released");

        // All entries requesting: round-robin order 0,1,2,3,0
        en = 1'b1;
        ent_val = 4'b1111;
        serve(0, 2, 5);
        serve(1, 2, 5);
        serve(2, 2, 5);
        serve(3, 2, 5);
        serve(0, 2, 5);
        ent_val = 4'b0000;
        tick();

        // Single requester 2; its descriptor changes after grant but pld_info must not
        ent_val = 4'b0100;
        tick();
        check("single_pend", pend, 1);
        check("single_idx", gnt_idx, 2);
        check("single_info", pld_info, {32'h1000_0002, 16'd102});
        ent_info[2].seq = 32'hdead_beef;
        ent_val = 4'b0000;
        serve(2, 1, 3);
        ent_info[2].seq = 32'h1000_0002;

        // en low blocks grants; raising it grants entry 0 (ptr=3 wraps to 0)
        en = 1'b0;
        ent_val = 4'b0011;
        repeat (3) tick();
        check("en_off_pend", pend, 0);
        check("en_off_busy", busy, 0);
        en = 1'b1;
        tick();
        check("en_on_pend", pend, 1);
        check("en_on_idx", gnt_idx, 0);
        serve(0, 2, 5);
        ent_val = 4'b0000;

        // Watchdog: send never asserted
        ent_val = 4'b0010;
        tick();
        check("wd_grant_idx", gnt_idx, 1);
        ent_val = 4'b0000;
        c = 0;
        while (ent_err == 0 && c < 40) begin
            tick();
            c++;
        end
        check("wd_latency", c, 16);
        check("wd_err", ent_err, 4'b0010);
        check("wd_pend_drop", pend, 0);
        $display("[TB] xfer idx=1 watchdog after %0d cycles", c);
        tick();
        check("wd_busy_low", busy, 0);
        ent_val = 4'b0110;
        serve(2, 1, 2);
        ent_val = 4'b0000;

        // sent coincides with watchdog expiry: ack wins
        ent_val = 4'b0001;
        tick();
        check("tie_idx", gnt_idx, 0);
        ent_val = 4'b0000;
        send = 1'b1;
        tick();
        send = 1'b0;
        repeat (14) tick();
        sent = 1'b1;
        tick();
        sent = 1'b0;
        check("tie_ack", ent_ack, 4'b0001);
        check("tie_no_err", ent_err, 0);
        $display("[TB] xfer idx=0 sent on watchdog expiry");
        repeat (2) tick();

        // Reset during XMIT of entry 3
        ent_val = 4'b1000;
        tick();
        check("rx_idx", gnt_idx, 3);
        send = 1'b1;
        tick();
        send = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("rx_pend", pend, 0);
        check("rx_busy", busy, 0);
        check("rx_ack", ent_ack, 0);
        check("rx_err", ent_err, 0);
        check("rx_gnt_idx", gnt_idx, 0);
        check("rx_pld_info", pld_info, 0);
        $display("[TB] xfer idx=3 abandoned by reset");
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_pend", pend, 1);
        check("post_rst_idx", gnt_idx, 3);
        ent_val = 4'b0000;
        serve(3, 1, 2);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
